// File: rtl/stage_instruction_fetch_queued.sv
// stage_instruction_fetch_queued: in-order instruction prefetch queue between imem and decode, with redirect squash
// Ports:
//   clk, reset (async, active-high), reset_vector_addr: clocking and first fetch address
//   if_stall: blocks new requests; de_stall/de_clear: hold/zero the decode register
//   ex_pc_src/ex_pc_target: redirect strobe and target
//   imem_req/imem_addr/imem_gnt: request handshake; imem_rvalid/imem_rdata: in-order responses
//   de_instr/de_pc/de_pc_plus4/de_valid: decode pipeline register
module stage_instruction_fetch_queued #(
  parameter int XLEN = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] reset_vector_addr,
  input  logic            if_stall,
  input  logic            de_stall,
  input  logic            de_clear,
  input  logic            ex_pc_src,
  input  logic [XLEN-1:0] ex_pc_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] de_instr,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc_plus4,
  output logic            de_valid
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [XLEN-1:0] r_fetch_pc, r_resp_pc;
  logic [OW-1:0]   r_inflight, r_drop_cnt;
  logic [XLEN-1:0] r_q_instr [QUEUE_DEPTH];
  logic [XLEN-1:0] r_q_pc [QUEUE_DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_accept, w_drop, w_push, w_pop;
  // a request is only issued if every live response already has a reserved queue slot
  assign imem_req = ~reset & ~if_stall & ~ex_pc_src & (int'(r_inflight) < MAX_OUTSTANDING) &
                    (int'(r_inflight) - int'(r_drop_cnt) + int'(r_count) < QUEUE_DEPTH);
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req & imem_gnt;
  assign w_drop    = r_drop_cnt != '0;
  assign w_push    = imem_rvalid & ~w_drop & ~ex_pc_src;
  // popping the head is exactly the decode-load condition
  assign w_pop     = (r_count != '0) & ~ex_pc_src & ~de_clear & ~de_stall;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_fetch_pc <= reset_vector_addr;
      r_resp_pc  <= reset_vector_addr;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (ex_pc_src) begin
      // everything still outstanding (minus a response landing now) is stale
      r_fetch_pc <= ex_pc_target;
      r_resp_pc  <= ex_pc_target;
      r_inflight <= r_inflight - OW'(imem_rvalid);
      r_drop_cnt <= r_inflight - OW'(imem_rvalid);
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      r_inflight <= r_inflight + OW'(w_accept) - OW'(imem_rvalid);
      if (imem_rvalid & w_drop) r_drop_cnt <= r_drop_cnt - OW'(1);
      if (w_push) begin
        r_resp_pc <= r_resp_pc + XLEN'(4);
        r_wr_ptr  <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      de_valid    <= 1'b0;
      de_instr    <= '0;
      de_pc       <= '0;
      de_pc_plus4 <= '0;
    end else if (de_clear | ~de_stall) begin
      de_valid    <= w_pop;
      de_instr    <= w_pop ? r_q_instr[r_rd_ptr] : '0;
      de_pc       <= w_pop ? r_q_pc[r_rd_ptr] : '0;
      de_pc_plus4 <= w_pop ? r_q_pc[r_rd_ptr] + XLEN'(4) : '0;
    end
endmodule

// File: tb/tb_stage_instruction_fetch_queued.sv
// tb_stage_instruction_fetch_queued: randomized bench with a program-order stream model and in-order memory model
module tb_stage_instruction_fetch_queued;
  logic        clk = 1'b0;
  logic        reset, if_stall, de_stall, de_clear, ex_pc_src;
  logic        imem_req, imem_gnt, imem_rvalid, de_valid;
  logic [31:0] reset_vector_addr, ex_pc_target, imem_addr, imem_rdata;
  logic [31:0] de_instr, de_pc, de_pc_plus4;
  int          errors = 0, checks = 0;
  logic [31:0] mem_addr_q[$];
  int          mem_age_q[$], mem_lat_q[$];
  logic [31:0] exp_fetch, exp_de, prev_instr, prev_pc, prev_p4, hold_addr;
  logic        prev_v, hold_v;
  int          n_de, gnt_pct, lat_lo, lat_hi;
  stage_instruction_fetch_queued dut (
    .clk(clk), .reset(reset), .reset_vector_addr(reset_vector_addr),
    .if_stall(if_stall), .de_stall(de_stall), .de_clear(de_clear),
    .ex_pc_src(ex_pc_src), .ex_pc_target(ex_pc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .de_instr(de_instr), .de_pc(de_pc), .de_pc_plus4(de_pc_plus4), .de_valid(de_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] code_of(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction
  task automatic drive_mem();
    imem_gnt = $urandom_range(99) < gnt_pct;
    imem_rvalid = (mem_addr_q.size() > 0) ? (mem_age_q[0] >= mem_lat_q[0]) : 1'b0;
    imem_rdata = imem_rvalid ? code_of(mem_addr_q[0]) : $urandom;
  endtask
  task automatic cyc();
    logic acc, rv, red, clr, stl;
    logic [31:0] a, tgt;
    #1;
    if (hold_v && imem_req) begin
      checks++;
      if (imem_addr !== hold_addr) begin
        errors++;
        $display("FAIL addr_hold: imem_addr=%h required %h", imem_addr, hold_addr);
      end
    end
    hold_v = imem_req & ~imem_gnt;
    hold_addr = imem_addr;
    acc = imem_req & imem_gnt;
    a = imem_addr;
    rv = imem_rvalid;
    red = ex_pc_src;
    tgt = ex_pc_target;
    clr = de_clear;
    stl = de_stall;
    if (red) begin
      checks++;
      if (imem_req !== 1'b0) begin
        errors++;
        $display("FAIL req_in_redirect: imem_req=%b required 0", imem_req);
      end
    end
    @(posedge clk);
    #1;
    foreach (mem_age_q[i]) mem_age_q[i]++;
    if (rv) begin
      void'(mem_addr_q.pop_front());
      void'(mem_age_q.pop_front());
      void'(mem_lat_q.pop_front());
    end
    if (acc) begin
      checks++;
      if (a !== exp_fetch) begin
        errors++;
        $display("FAIL fetch_addr: imem_addr=%h required %h", a, exp_fetch);
      end
      exp_fetch += 32'd4;
      mem_addr_q.push_back(a);
      mem_age_q.push_back(1);
      mem_lat_q.push_back(int'($urandom_range(lat_hi, lat_lo)));
    end
    checks++;
    if (clr) begin
      if ({de_valid, de_instr, de_pc, de_pc_plus4} !== '0) begin
        errors++;
        $display("FAIL clear: de_valid=%b de_pc=%h de_instr=%h required all zero", de_valid, de_pc, de_instr);
      end
    end else if (stl) begin
      if ({de_valid, de_instr, de_pc, de_pc_plus4} !== {prev_v, prev_instr, prev_pc, prev_p4}) begin
        errors++;
        $display("FAIL stall_hold: de_valid=%b de_pc=%h required %b %h", de_valid, de_pc, prev_v, prev_pc);
      end
    end else if (de_valid && !red) begin
      if (de_pc !== exp_de || de_instr !== code_of(exp_de) || de_pc_plus4 !== exp_de + 32'd4) begin
        errors++;
        $display("FAIL stream: de_pc=%h de_instr=%h de_pc_plus4=%h required %h %h %h",
                 de_pc, de_instr, de_pc_plus4, exp_de, code_of(exp_de), exp_de + 32'd4);
      end
      exp_de += 32'd4;
      n_de++;
    end else if ({de_valid, de_instr, de_pc, de_pc_plus4} !== '0) begin
      errors++;
      $display("FAIL bubble: de_valid=%b de_pc=%h de_instr=%h required all zero", de_valid, de_pc, de_instr);
    end
    if (red) begin
      exp_fetch = tgt;
      exp_de = tgt;
    end
    {prev_v, prev_instr, prev_pc, prev_p4} = {de_valid, de_instr, de_pc, de_pc_plus4};
    @(negedge clk);
    drive_mem();
  endtask
  task automatic run_until(int n, int budget);
    int c = 0;
    while (n_de < n && c < budget) begin
      cyc();
      c++;
    end
    checks++;
    if (n_de < n) begin
      errors++;
      $display("FAIL progress: delivered=%0d required %0d", n_de, n);
    end
  endtask
  task automatic do_reset(logic [31:0] vec);
    reset = 1'b1;
    reset_vector_addr = vec;
    {if_stall, de_stall, de_clear, ex_pc_src} = '0;
    ex_pc_target = '0;
    {imem_gnt, imem_rvalid} = '0;
    imem_rdata = '0;
    mem_addr_q.delete();
    mem_age_q.delete();
    mem_lat_q.delete();
    hold_v = 1'b0;
    {prev_v, prev_instr, prev_pc, prev_p4} = '0;
    n_de = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req, de_valid, de_instr, de_pc, de_pc_plus4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: imem_req=%b de_valid=%b de_pc=%h required all zero", imem_req, de_valid, de_pc);
    end
    reset = 1'b0;
    exp_fetch = vec;
    exp_de = vec;
    drive_mem();
  endtask
  task automatic test_reset_stream();
    gnt_pct = 100;
    lat_lo = 1;
    lat_hi = 1;
    do_reset(32'h100);
    // accept on the first edge, response pushed on the second, decode loaded on the third
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++;
      if (de_valid !== (i == 3)) begin
        errors++;
        $display("FAIL first_latency: edge %0d de_valid=%b required %b", i, de_valid, i == 3);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (de_valid !== 1'b1) begin
        errors++;
        $display("FAIL throughput: cycle %0d de_valid=%b required 1", i, de_valid);
      end
    end
  endtask
  task automatic test_backpressure();
    de_stall = 1'b1;
    repeat (10) cyc();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_req: imem_req=%b required 0", imem_req);
    end
    de_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (de_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain: cycle %0d de_valid=%b required 1", i, de_valid);
      end
    end
  endtask
  task automatic test_priority();
    de_clear = 1'b1;
    de_stall = 1'b1;
    cyc();
    checks++;
    if (de_valid !== 1'b0 || de_pc !== 32'h0) begin
      errors++;
      $display("FAIL clear_priority: de_valid=%b de_pc=%h required 0 0", de_valid, de_pc);
    end
    de_clear = 1'b0;
    de_stall = 1'b0;
    run_until(n_de + 3, 50);
  endtask
  task automatic test_redirect_inflight();
    int c = 0;
    lat_lo = 3;
    lat_hi = 3;
    repeat (6) cyc();
    while (!(mem_addr_q.size() == 2 && !imem_rvalid) && c < 20) begin
      cyc();
      c++;
    end
    checks++;
    if (!(mem_addr_q.size() == 2 && !imem_rvalid)) begin
      errors++;
      $display("FAIL inflight_setup: outstanding=%0d required 2", mem_addr_q.size());
    end
    ex_pc_src = 1'b1;
    ex_pc_target = 32'h200;
    cyc();
    ex_pc_src = 1'b0;
    run_until(n_de + 4, 80);
  endtask
  task automatic test_redirect_rvalid();
    int c = 0;
    lat_lo = 2;
    lat_hi = 2;
    repeat (4) cyc();
    while (!(imem_rvalid && mem_addr_q.size() == 2) && c < 20) begin
      cyc();
      c++;
    end
    checks++;
    if (!(imem_rvalid && mem_addr_q.size() == 2)) begin
      errors++;
      $display("FAIL rvalid_setup: rvalid=%b outstanding=%0d required 1 2", imem_rvalid, mem_addr_q.size());
    end
    ex_pc_src = 1'b1;
    ex_pc_target = 32'h300;
    cyc();
    ex_pc_src = 1'b0;
    run_until(n_de + 4, 80);
  endtask
  task automatic test_wrap_random();
    gnt_pct = 60;
    lat_lo = 1;
    lat_hi = 4;
    do_reset(32'hFFFF_FFF8);
    run_until(4, 200);
    for (int i = 0; i < 300; i++) begin
      if_stall = $urandom_range(9) == 0;
      de_stall = $urandom_range(5) == 0;
      de_clear = $urandom_range(19) == 0;
      ex_pc_src = $urandom_range(24) == 0;
      ex_pc_target = $urandom & 32'hFFFF_FFFC;
      cyc();
    end
    {if_stall, de_stall, de_clear, ex_pc_src} = '0;
    run_until(n_de + 5, 200);
  endtask
  task automatic test_async_reset();
    gnt_pct = 100;
    lat_lo = 1;
    lat_hi = 1;
    run_until(n_de + 3, 50);
    #2;
    reset = 1'b1;
    reset_vector_addr = 32'h400;
    #1;
    checks++;
    if ({imem_req, de_valid, de_instr, de_pc, de_pc_plus4} !== '0) begin
      errors++;
      $display("FAIL async_reset: imem_req=%b de_valid=%b de_pc=%h required all zero", imem_req, de_valid, de_pc);
    end
    do_reset(32'h400);
    run_until(4, 50);
  endtask
  initial begin
    gnt_pct = 100;
    lat_lo = 1;
    lat_hi = 1;
    test_reset_stream();
    test_backpressure();
    test_priority();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_wrap_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
